// File: rtl/conv_layer_seq.sv
// conv_layer_seq
//   Time-multiplexed convolution layer. One image window and FILTER_TOTAL
//   kernels are captured over a valid/ready handshake. Each filter then
//   accumulates LANES signed fixed-point products per cycle. The
//   FILTER_TOTAL results are rounded, saturated and optionally ReLU'd, then
//   presented over a second valid/ready handshake.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   win_valid  window / kernels / relu valid
//   win_ready  block can accept a window (IDLE only, low while rst=1)
//   win_data   window, element e at [e*DATA_W +: DATA_W]
//   filt_data  kernels, filter f element e at [(f*K+e)*DATA_W +: DATA_W]
//   relu       clamp negative results to zero (sampled on accept)
//   out_valid  results valid
//   out_ready  downstream accepts results
//   out_data   filter f result at [f*DATA_W +: DATA_W]
//   busy       high in MAC or OUT state
module conv_layer_seq #(
    parameter int WINDOW_SIZE  = 3,
    parameter int CHANNEL_SIZE = 8,
    parameter int FILTER_TOTAL = 8,
    parameter int DATA_W       = 16,
    parameter int FRAC_W       = 8,
    parameter int LANES        = 4
) (
    input  logic                                                               clk,
    input  logic                                                               rst,
    input  logic                                                               win_valid,
    output logic                                                               win_ready,
    input  logic [WINDOW_SIZE*WINDOW_SIZE*CHANNEL_SIZE*DATA_W-1:0]              win_data,
    input  logic [FILTER_TOTAL*WINDOW_SIZE*WINDOW_SIZE*CHANNEL_SIZE*DATA_W-1:0] filt_data,
    input  logic                                                               relu,
    output logic                                                               out_valid,
    input  logic                                                               out_ready,
    output logic [FILTER_TOTAL*DATA_W-1:0]                                     out_data,
    output logic                                                               busy
);

    localparam int K       = WINDOW_SIZE * WINDOW_SIZE * CHANNEL_SIZE;
    localparam int MAC_CYC = K / LANES;
    localparam int ACC_W   = 2 * DATA_W + $clog2(K);
    localparam int IDX_W   = $clog2(MAC_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAC_CYC - 1);

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // A lane count that does not divide the window would leave a ragged
    // final MAC cycle, so such configurations are refused outright.
    if ((K % LANES) != 0) begin : gLanesCheck
        $error("conv_layer_seq: LANES must divide WINDOW_SIZE^2*CHANNEL_SIZE");
    end
    if (FRAC_W < 1) begin : gFracCheck
        $error("conv_layer_seq: FRAC_W must be at least 1");
    end

    logic [1:0]                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q;
    logic [K*DATA_W-1:0]                win_q;
    logic [FILTER_TOTAL*K*DATA_W-1:0]   filt_q;
    logic                               relu_q;
    logic signed [ACC_W-1:0]            acc_q   [FILTER_TOTAL];
    logic signed [ACC_W-1:0]            macSum  [FILTER_TOTAL];
    logic                               outValid_q;
    logic [FILTER_TOTAL*DATA_W-1:0]     outData_q;
    logic [FILTER_TOTAL*DATA_W-1:0]     postData;

    logic signed [DATA_W-1:0]           xElem, wElem;
    logic signed [2*DATA_W-1:0]         prod;
    logic signed [ACC_W-1:0]            sumR, rounded;

    // rst gates win_ready directly so no window can be accepted in a reset cycle.
    assign win_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;

    // Accumulator next values for the current slice of LANES elements, plus
    // the rounded/saturated/ReLU view of those sums. The post-processed view
    // is only latched on the final MAC cycle, when macSum already holds the
    // complete dot product.
    always_comb begin
        xElem    = '0;
        wElem    = '0;
        prod     = '0;
        sumR     = '0;
        rounded  = '0;
        postData = '0;
        for (int f = 0; f < FILTER_TOTAL; f++) begin
            macSum[f] = acc_q[f];
            for (int l = 0; l < LANES; l++) begin
                xElem     = win_q[(int'(idx_q) * LANES + l) * DATA_W +: DATA_W];
                wElem     = filt_q[(f * K + int'(idx_q) * LANES + l) * DATA_W +: DATA_W];
                prod      = (2*DATA_W)'(xElem) * (2*DATA_W)'(wElem);
                macSum[f] = macSum[f] + ACC_W'(prod);
            end
            sumR    = macSum[f] + HALF;
            rounded = sumR >>> FRAC_W;
            if (rounded > SAT_MAX) begin
                postData[f*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            end else if (rounded < SAT_MIN) begin
                postData[f*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            end else begin
                postData[f*DATA_W +: DATA_W] = rounded[DATA_W-1:0];
            end
            if (relu_q && rounded[ACC_W-1]) begin
                postData[f*DATA_W +: DATA_W] = '0;
            end
        end
    end

    // IDLE -> MAC -> OUT -> IDLE. MAC lasts exactly MAC_CYC cycles, so the
    // result appears in the 19th cycle after the accepting cycle at defaults
    // and a window can be accepted every MAC_CYC+2 cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_valid)          state_d = S_MAC;
            S_MAC:   if (idx_q == LAST_IDX)  state_d = S_OUT;
            S_OUT:   if (out_ready)          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Control, accumulators and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            for (int f = 0; f < FILTER_TOTAL; f++) begin
                acc_q[f] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        idx_q <= '0;
                        for (int f = 0; f < FILTER_TOTAL; f++) begin
                            acc_q[f] <= '0;
                        end
                    end
                end
                S_MAC: begin
                    for (int f = 0; f < FILTER_TOTAL; f++) begin
                        acc_q[f] <= macSum[f];
                    end
                    if (idx_q == LAST_IDX) begin
                        outData_q  <= postData;
                        outValid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture. The producer may drop its inputs right after the
    // handshake, so the whole window and kernel set are held locally.
    always_ff @(posedge clk) begin
        if (win_valid && win_ready) begin
            win_q  <= win_data;
            filt_q <= filt_data;
            relu_q <= relu;
        end
    end

endmodule
